// File: rtl/k_means_pkg.sv
// Shared types and helpers for the k-means cluster engine.
//   state_t    : top-level controller states
//   bits_for   : index width for n distinct values (minimum 1)
//   x/y/k/addr : derived port and RAM address widths
//   manhattan  : |ax-bx| + |ay-by|
package k_means_pkg;

    typedef enum logic [1:0] {CAPTURE, SCAN, DIVIDE, CHECK} state_t;

    function automatic int unsigned bits_for(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned x_width(input int unsigned width);
        return bits_for(width);
    endfunction

    function automatic int unsigned y_width(input int unsigned height);
        return bits_for(height);
    endfunction

    function automatic int unsigned k_width(input int unsigned max_k);
        return bits_for(max_k + 1);
    endfunction

    function automatic int unsigned addr_width(input int unsigned width, input int unsigned height,
                                               input int unsigned word_bits);
        return bits_for((width * height) / word_bits);
    endfunction

    function automatic int unsigned manhattan(input int unsigned ax, input int unsigned ay,
                                              input int unsigned bx, input int unsigned by);
        int unsigned dx;
        int unsigned dy;
        dx = (ax > bx) ? ax - bx : bx - ax;
        dy = (ay > by) ? ay - by : by - ay;
        return dx + dy;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
//   start_in    : load dividend/divisor (divisor is never zero)
//   quotient_out: floor(dividend/divisor), valid when done_out pulses
//   done_out    : one-cycle pulse W cycles after start_in
module seq_divider #(
    parameter int unsigned W = 26,
    localparam int unsigned CW = (W < 2) ? 1 : $clog2(W + 1)
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         start_in,
    input  logic [W-1:0] dividend_in,
    input  logic [W-1:0] divisor_in,
    output logic [W-1:0] quotient_out,
    output logic         done_out
);

    logic [W-1:0]  rem;
    logic [W-1:0]  dvs;
    logic [CW-1:0] cnt;
    logic          running;
    logic [W:0]    trial_c;
    logic          ge_c;

    always_comb begin
        trial_c = {rem, quotient_out[W-1]};
        ge_c    = trial_c >= {1'b0, dvs};
    end

    // quotient_out doubles as the dividend shift register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rem          <= '0;
            dvs          <= '0;
            cnt          <= '0;
            running      <= 1'b0;
            quotient_out <= '0;
            done_out     <= 1'b0;
        end else begin
            done_out <= 1'b0;
            if (start_in) begin
                rem          <= '0;
                dvs          <= divisor_in;
                quotient_out <= dividend_in;
                cnt          <= CW'(W);
                running      <= 1'b1;
            end else if (running) begin
                rem          <= ge_c ? W'(trial_c - {1'b0, dvs}) : trial_c[W-1:0];
                quotient_out <= {quotient_out[W-2:0], ge_c};
                cnt          <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    running  <= 1'b0;
                    done_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port block RAM, read-first on both ports.
// HIGH_PERFORMANCE adds an output register (2-cycle read latency),
// LOW_LATENCY reads in 1 cycle. Contents are never reset.
//   addra/addrb, dina/dinb, wea/web, ena/enb : port address, data, write, enable
//   rsta/rstb, regcea/regceb                 : output register reset / clock enable
//   douta/doutb                              : read data
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int unsigned RAM_WIDTH       = 18,
    parameter int unsigned RAM_DEPTH       = 1024,
    parameter              RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    localparam int unsigned AW             = (RAM_DEPTH < 2) ? 1 : $clog2(RAM_DEPTH)
) (
    input  logic [AW-1:0]        addra,
    input  logic [AW-1:0]        addrb,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic [RAM_WIDTH-1:0] dinb,
    input  logic                 clka,
    input  logic                 wea,
    input  logic                 web,
    input  logic                 ena,
    input  logic                 enb,
    input  logic                 rsta,
    input  logic                 rstb,
    input  logic                 regcea,
    input  logic                 regceb,
    output logic [RAM_WIDTH-1:0] douta,
    output logic [RAM_WIDTH-1:0] doutb
);

    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a;
    logic [RAM_WIDTH-1:0] ram_data_b;

    // Both ports in one process: read-first, old data returned on a write.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) ram[addra] <= dina;
            ram_data_a <= ram[addra];
        end
        if (enb) begin
            if (web) ram[addrb] <= dinb;
            ram_data_b <= ram[addrb];
        end
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
        logic unused_ctrl;
        assign unused_ctrl = rsta ^ rstb ^ regcea ^ regceb;
        assign douta = ram_data_a;
        assign doutb = ram_data_b;
    end else begin : g_out_reg
        always_ff @(posedge clka) begin
            if (rsta)        douta <= '0;
            else if (regcea) douta <= ram_data_a;
            if (rstb)        doutb <= '0;
            else if (regceb) doutb <= ram_data_b;
        end
    end

endmodule

// File: rtl/k_means_cluster_engine.sv
// Frame-level k-means engine: packs a binary mask into RAM, then iterates
// assign/accumulate/divide over up to MAX_K clusters until the centroids
// settle or MAX_ITER iterations have run.
//   seed_*          : initial centroids, loaded while idle
//   k_in            : active cluster count, latched at frame_done_in
//   pixel_* / x,y   : raster mask stream
//   busy_out        : clustering in progress
//   data_valid_out  : one-cycle pulse with mass/iteration/convergence results
//   centroids_*_out : live centroid registers
module k_means_cluster_engine
    import k_means_pkg::*;
#(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 180,
    parameter int unsigned WORD_BITS   = 64,
    parameter int unsigned MAX_K       = 7,
    parameter int unsigned MAX_ITER    = 30,
    parameter int unsigned SUM_W       = 26,
    parameter int unsigned CONV_THRESH = 0,
    localparam int unsigned XW = x_width(WIDTH),
    localparam int unsigned YW = y_width(HEIGHT),
    localparam int unsigned KW = k_width(MAX_K),
    localparam int unsigned IW = bits_for(MAX_ITER + 1)
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        seed_valid_in,
    input  logic [MAX_K-1:0][XW-1:0]    seed_x_in,
    input  logic [MAX_K-1:0][YW-1:0]    seed_y_in,
    input  logic [KW-1:0]               k_in,
    input  logic                        pixel_valid_in,
    input  logic [XW-1:0]               x_in,
    input  logic [YW-1:0]               y_in,
    input  logic                        mask_in,
    input  logic                        frame_done_in,
    output logic                        busy_out,
    output logic                        data_valid_out,
    output logic [MAX_K-1:0][XW-1:0]    centroids_x_out,
    output logic [MAX_K-1:0][YW-1:0]    centroids_y_out,
    output logic [MAX_K-1:0][SUM_W-1:0] mass_out,
    output logic [IW-1:0]               iterations_out,
    output logic                        converged_out
);

    localparam int unsigned WPR   = WIDTH / WORD_BITS;
    localparam int unsigned WORDS = WPR * HEIGHT;
    localparam int unsigned AW    = addr_width(WIDTH, HEIGHT, WORD_BITS);
    localparam int unsigned BW    = bits_for(WORD_BITS);
    localparam int unsigned SCW   = bits_for(WORDS + 3);
    localparam int unsigned KIW   = bits_for(MAX_K);

    state_t                      state;
    logic [KW-1:0]               k_eff;
    logic [IW-1:0]               iter_cnt;
    logic [SCW-1:0]              scan_cnt;
    logic [WORD_BITS-1:0]        pack_reg;
    logic [MAX_K-1:0][XW-1:0]    shadow_x;
    logic [MAX_K-1:0][YW-1:0]    shadow_y;
    logic [MAX_K-1:0][SUM_W-1:0] x_sum, y_sum, mass;

    logic                        p1_valid, p2_valid;
    logic [XW-1:0]               p1_xbase, p2_xbase;
    logic [YW-1:0]               p1_y, p2_y;
    logic [WORD_BITS-1:0]        rd_word;
    logic [WORD_BITS-1:0]        unused_doutb;

    logic                        div_start, div_done, div_active, div_phase;
    logic [KW-1:0]               div_idx;
    logic [SUM_W-1:0]            div_dividend, div_divisor, div_quotient;

    logic                        pix_ok_c, wr_en_c, scan_issue_c;
    logic [BW-1:0]               bit_c;
    logic [WORD_BITS-1:0]        word_c;
    logic [AW-1:0]               wr_addr_c, rd_addr_c;
    logic [MAX_K-1:0][SUM_W-1:0] add_x_c, add_y_c, add_m_c;
    int unsigned                 max_move_c;

    // Capture-side packing and RAM write word
    always_comb begin
        pix_ok_c  = (state == CAPTURE) && pixel_valid_in &&
                    (32'(x_in) < WIDTH) && (32'(y_in) < HEIGHT);
        bit_c     = BW'(32'(x_in) % WORD_BITS);
        word_c    = (bit_c == '0) ? '0 : pack_reg;
        word_c[bit_c] = word_c[bit_c] | mask_in;
        wr_en_c   = pix_ok_c && (32'(bit_c) == WORD_BITS - 1);
        wr_addr_c = AW'(32'(y_in) * WPR + 32'(x_in) / WORD_BITS);
        scan_issue_c = (state == SCAN) && (32'(scan_cnt) < WORDS);
        rd_addr_c    = AW'(scan_cnt);
    end

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH      (WORD_BITS),
        .RAM_DEPTH      (WORDS),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE")
    ) u_ram (
        .addra (rd_addr_c),
        .addrb (wr_addr_c),
        .dina  ('0),
        .dinb  (word_c),
        .clka  (clk_in),
        .wea   (1'b0),
        .web   (wr_en_c),
        .ena   (1'b1),
        .enb   (wr_en_c),
        .rsta  (1'b0),
        .rstb  (1'b0),
        .regcea(1'b1),
        .regceb(1'b1),
        .douta (rd_word),
        .doutb (unused_doutb)
    );

    seq_divider #(.W(SUM_W)) u_div (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .start_in    (div_start),
        .dividend_in (div_dividend),
        .divisor_in  (div_divisor),
        .quotient_out(div_quotient),
        .done_out    (div_done)
    );

    // Word position travels alongside the 2-cycle RAM read
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            p1_xbase <= '0;
            p2_xbase <= '0;
            p1_y     <= '0;
            p2_y     <= '0;
        end else begin
            p1_valid <= scan_issue_c;
            p1_xbase <= XW'((32'(scan_cnt) % WPR) * WORD_BITS);
            p1_y     <= YW'(32'(scan_cnt) / WPR);
            p2_valid <= p1_valid;
            p2_xbase <= p1_xbase;
            p2_y     <= p1_y;
        end
    end

    // Per-word nearest-centroid assignment; strict '<' keeps ties on the lowest index
    always_comb begin
        int unsigned px;
        int unsigned best_d;
        int unsigned d;
        logic [KIW-1:0] best;
        add_x_c = '0;
        add_y_c = '0;
        add_m_c = '0;
        for (int i = 0; i < int'(WORD_BITS); i++) begin
            px     = 32'(p2_xbase) + 32'(i);
            best   = '0;
            best_d = manhattan(px, 32'(p2_y), 32'(centroids_x_out[0]), 32'(centroids_y_out[0]));
            for (int j = 1; j < int'(MAX_K); j++) begin
                d = manhattan(px, 32'(p2_y), 32'(centroids_x_out[j]), 32'(centroids_y_out[j]));
                if ((32'(j) < 32'(k_eff)) && (d < best_d)) begin
                    best   = KIW'(j);
                    best_d = d;
                end
            end
            if (p2_valid && rd_word[i]) begin
                add_x_c[best] = add_x_c[best] + SUM_W'(px);
                add_y_c[best] = add_y_c[best] + SUM_W'(p2_y);
                add_m_c[best] = add_m_c[best] + SUM_W'(1);
            end
        end
    end

    // Largest centroid movement over the active clusters
    always_comb begin
        int unsigned mv;
        max_move_c = 0;
        for (int j = 0; j < int'(MAX_K); j++) begin
            mv = manhattan(32'(shadow_x[j]), 32'(shadow_y[j]),
                           32'(centroids_x_out[j]), 32'(centroids_y_out[j]));
            if ((32'(j) < 32'(k_eff)) && (mv > max_move_c)) max_move_c = mv;
        end
    end

    // Controller
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state           <= CAPTURE;
            busy_out        <= 1'b0;
            data_valid_out  <= 1'b0;
            centroids_x_out <= '0;
            centroids_y_out <= '0;
            mass_out        <= '0;
            iterations_out  <= '0;
            converged_out   <= 1'b0;
            k_eff           <= '0;
            iter_cnt        <= '0;
            scan_cnt        <= '0;
            pack_reg        <= '0;
            shadow_x        <= '0;
            shadow_y        <= '0;
            x_sum           <= '0;
            y_sum           <= '0;
            mass            <= '0;
            div_start       <= 1'b0;
            div_active      <= 1'b0;
            div_phase       <= 1'b0;
            div_idx         <= '0;
            div_dividend    <= '0;
            div_divisor     <= '0;
        end else begin
            data_valid_out <= 1'b0;
            div_start      <= 1'b0;
            case (state)
                CAPTURE: begin
                    if (pix_ok_c) pack_reg <= word_c;
                    if (seed_valid_in) begin
                        centroids_x_out <= seed_x_in;
                        centroids_y_out <= seed_y_in;
                    end
                    if (frame_done_in) begin
                        k_eff    <= (k_in == '0) ? KW'(1) :
                                    ((32'(k_in) > MAX_K) ? KW'(MAX_K) : k_in);
                        iter_cnt <= '0;
                        scan_cnt <= '0;
                        x_sum    <= '0;
                        y_sum    <= '0;
                        mass     <= '0;
                        busy_out <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    for (int j = 0; j < int'(MAX_K); j++) begin
                        x_sum[j] <= x_sum[j] + add_x_c[j];
                        y_sum[j] <= y_sum[j] + add_y_c[j];
                        mass[j]  <= mass[j] + add_m_c[j];
                    end
                    if (32'(scan_cnt) == WORDS + 2) begin
                        shadow_x   <= centroids_x_out;
                        shadow_y   <= centroids_y_out;
                        div_idx    <= '0;
                        div_phase  <= 1'b0;
                        div_active <= 1'b0;
                        state      <= DIVIDE;
                    end else begin
                        scan_cnt <= scan_cnt + SCW'(1);
                    end
                end
                DIVIDE: begin
                    // x quotient then y quotient per cluster; empty clusters keep their centroid
                    if (div_idx >= k_eff) begin
                        state <= CHECK;
                    end else if (mass[KIW'(div_idx)] == '0) begin
                        div_idx <= div_idx + KW'(1);
                    end else if (!div_active) begin
                        div_start    <= 1'b1;
                        div_active   <= 1'b1;
                        div_dividend <= div_phase ? y_sum[KIW'(div_idx)] : x_sum[KIW'(div_idx)];
                        div_divisor  <= mass[KIW'(div_idx)];
                    end else if (div_done) begin
                        div_active <= 1'b0;
                        div_phase  <= ~div_phase;
                        if (!div_phase) begin
                            shadow_x[KIW'(div_idx)] <= XW'(div_quotient);
                        end else begin
                            shadow_y[KIW'(div_idx)] <= YW'(div_quotient);
                            div_idx <= div_idx + KW'(1);
                        end
                    end
                end
                CHECK: begin
                    centroids_x_out <= shadow_x;
                    centroids_y_out <= shadow_y;
                    iter_cnt        <= iter_cnt + IW'(1);
                    if ((max_move_c <= CONV_THRESH) || (32'(iter_cnt) + 1 == MAX_ITER)) begin
                        data_valid_out <= 1'b1;
                        mass_out       <= mass;
                        iterations_out <= iter_cnt + IW'(1);
                        converged_out  <= (max_move_c <= CONV_THRESH);
                        busy_out       <= 1'b0;
                        state          <= CAPTURE;
                    end else begin
                        x_sum    <= '0;
                        y_sum    <= '0;
                        mass     <= '0;
                        scan_cnt <= '0;
                        state    <= SCAN;
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

endmodule

// File: tb/tb_k_means_cluster_engine.sv
// Directed and randomized checks of k_means_cluster_engine against a
// frame-level k-means reference model. A second instance with MAX_ITER=1
// shares all inputs and covers the iteration cap.
module tb_k_means_cluster_engine;

    localparam int W = 16, H = 4, WB = 8, K = 3, SW = 12;

    logic clk_in = 1'b0;
    logic rst_in;
    logic seed_valid_in, pixel_valid_in, mask_in, frame_done_in;
    logic [K-1:0][3:0] seed_x_in;
    logic [K-1:0][1:0] seed_y_in;
    logic [1:0] k_in;
    logic [3:0] x_in;
    logic [1:0] y_in;

    logic busy, dv, conv, c_busy, c_dv, c_conv;
    logic [K-1:0][3:0]  cx, c_cx;
    logic [K-1:0][1:0]  cy, c_cy;
    logic [K-1:0][SW-1:0] mass, c_mass;
    logic [4:0] iters;
    logic [0:0] c_iters;

    always #5 clk_in = ~clk_in;

    k_means_cluster_engine #(.WIDTH(W), .HEIGHT(H), .WORD_BITS(WB), .MAX_K(K),
                             .MAX_ITER(30), .SUM_W(SW), .CONV_THRESH(0)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .seed_valid_in(seed_valid_in),
        .seed_x_in(seed_x_in), .seed_y_in(seed_y_in), .k_in(k_in),
        .pixel_valid_in(pixel_valid_in), .x_in(x_in), .y_in(y_in), .mask_in(mask_in),
        .frame_done_in(frame_done_in), .busy_out(busy), .data_valid_out(dv),
        .centroids_x_out(cx), .centroids_y_out(cy), .mass_out(mass),
        .iterations_out(iters), .converged_out(conv));

    k_means_cluster_engine #(.WIDTH(W), .HEIGHT(H), .WORD_BITS(WB), .MAX_K(K),
                             .MAX_ITER(1), .SUM_W(SW), .CONV_THRESH(0)) dut_cap (
        .clk_in(clk_in), .rst_in(rst_in), .seed_valid_in(seed_valid_in),
        .seed_x_in(seed_x_in), .seed_y_in(seed_y_in), .k_in(k_in),
        .pixel_valid_in(pixel_valid_in), .x_in(x_in), .y_in(y_in), .mask_in(mask_in),
        .frame_done_in(frame_done_in), .busy_out(c_busy), .data_valid_out(c_dv),
        .centroids_x_out(c_cx), .centroids_y_out(c_cy), .mass_out(c_mass),
        .iterations_out(c_iters), .converged_out(c_conv));

    int n_assert = 0;
    int n_fail   = 0;

    bit frame [H][W];
    int seed_x [K];
    int seed_y [K];
    int e_cx [K], e_cy [K], e_mass [K];
    int e_iter, e_conv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference k-means over the bench frame, straight from the algorithm definition
    task automatic model(input int k, input int max_iter);
        int kk, sx[K], sy[K], m[K], best, bd, d, mv, nx, ny;
        kk = (k < 1) ? 1 : ((k > K) ? K : k);
        for (int j = 0; j < K; j++) begin e_cx[j] = seed_x[j]; e_cy[j] = seed_y[j]; end
        e_iter = 0;
        forever begin
            for (int j = 0; j < K; j++) begin sx[j] = 0; sy[j] = 0; m[j] = 0; end
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    if (frame[y][x]) begin
                        best = 0;
                        bd = absdiff(x, e_cx[0]) + absdiff(y, e_cy[0]);
                        for (int j = 1; j < kk; j++) begin
                            d = absdiff(x, e_cx[j]) + absdiff(y, e_cy[j]);
                            if (d < bd) begin bd = d; best = j; end
                        end
                        sx[best] += x; sy[best] += y; m[best] += 1;
                    end
            mv = 0;
            for (int j = 0; j < kk; j++)
                if (m[j] > 0) begin
                    nx = sx[j] / m[j];
                    ny = sy[j] / m[j];
                    d = absdiff(nx, e_cx[j]) + absdiff(ny, e_cy[j]);
                    if (d > mv) mv = d;
                    e_cx[j] = nx; e_cy[j] = ny;
                end
            e_iter++;
            if (mv == 0 || e_iter == max_iter) begin
                e_conv = (mv == 0) ? 1 : 0;
                for (int j = 0; j < K; j++) e_mass[j] = m[j];
                break;
            end
        end
    endtask

    task automatic drive_seeds();
        for (int j = 0; j < K; j++) begin
            seed_x_in[j] = 4'(seed_x[j]);
            seed_y_in[j] = 2'(seed_y[j]);
        end
    endtask

    task automatic load_seeds();
        @(negedge clk_in);
        drive_seeds();
        seed_valid_in = 1'b1;
        @(negedge clk_in);
        seed_valid_in = 1'b0;
    endtask

    task automatic send_frame(input int k, input bit seeds_at_done);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                @(negedge clk_in);
                pixel_valid_in = 1'b1;
                x_in = 4'(x); y_in = 2'(y); mask_in = frame[y][x];
                end
        @(negedge clk_in);
        pixel_valid_in = 1'b0; mask_in = 1'b0;
        k_in = 2'(k);
        frame_done_in = 1'b1;
        if (seeds_at_done) begin drive_seeds(); seed_valid_in = 1'b1; end
        @(negedge clk_in);
        frame_done_in = 1'b0; seed_valid_in = 1'b0;
    endtask

    task automatic wait_pulse(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(negedge clk_in);
            if (dv) seen = 1'b1;
        end
        check({tag, "_pulse_seen"}, 32'(seen), 1);
        @(negedge clk_in);
        check({tag, "_pulse_width"}, 32'(dv), 0);
    endtask

    task automatic compare_main(input string tag, input int k);
        model(k, 30);
        for (int j = 0; j < K; j++) begin
            check($sformatf("%s_cx%0d", tag, j), 32'(cx[j]), 32'(e_cx[j]));
            check($sformatf("%s_cy%0d", tag, j), 32'(cy[j]), 32'(e_cy[j]));
            check($sformatf("%s_mass%0d", tag, j), 32'(mass[j]), 32'(e_mass[j]));
        end
        check({tag, "_iters"}, 32'(iters), 32'(e_iter));
        check({tag, "_conv"}, 32'(conv), 32'(e_conv));
    endtask

    task automatic compare_cap(input string tag, input int k);
        model(k, 1);
        for (int j = 0; j < K; j++) begin
            check($sformatf("%s_cap_cx%0d", tag, j), 32'(c_cx[j]), 32'(e_cx[j]));
            check($sformatf("%s_cap_cy%0d", tag, j), 32'(c_cy[j]), 32'(e_cy[j]));
            check($sformatf("%s_cap_mass%0d", tag, j), 32'(c_mass[j]), 32'(e_mass[j]));
        end
        check({tag, "_cap_iters"}, 32'(c_iters), 32'(e_iter));
        check({tag, "_cap_conv"}, 32'(c_conv), 32'(e_conv));
    endtask

    task automatic clear_frame();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) frame[y][x] = 1'b0;
    endtask

    task automatic single_blob_frame();
        clear_frame();
        frame[1][4] = 1'b1; frame[1][6] = 1'b1; frame[3][4] = 1'b1; frame[3][6] = 1'b1;
    endtask

    task automatic two_blob_frame();
        clear_frame();
        for (int y = 0; y < 2; y++) for (int x = 1; x <= 2; x++) frame[y][x] = 1'b1;
        for (int y = 2; y < 4; y++) for (int x = 13; x <= 14; x++) frame[y][x] = 1'b1;
    endtask

    task automatic set_seeds(input int x0, input int y0, input int x1, input int y1,
                             input int x2, input int y2);
        seed_x[0] = x0; seed_y[0] = y0; seed_x[1] = x1; seed_y[1] = y1;
        seed_x[2] = x2; seed_y[2] = y2;
    endtask

    initial begin
        int k, dens;
        rst_in = 1'b1;
        seed_valid_in = 1'b0; pixel_valid_in = 1'b0; mask_in = 1'b0; frame_done_in = 1'b0;
        seed_x_in = '0; seed_y_in = '0; k_in = '0; x_in = '0; y_in = '0;

        // Reset state
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_dv", 32'(dv), 0);
        check("rst_cx", 32'(cx), 0);
        check("rst_iters", 32'(iters), 0);
        check("rst_conv", 32'(conv), 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;

        // Single blob, k=1
        single_blob_frame();
        set_seeds(0, 0, 0, 0, 0, 0);
        load_seeds();
        send_frame(1, 1'b0);
        check("blob_busy", 32'(busy), 1);
        wait_pulse("blob");
        compare_main("blob", 1);
        check("blob_const_cx", 32'(cx[0]), 5);
        check("blob_const_cy", 32'(cy[0]), 2);
        check("blob_const_mass", 32'(mass[0]), 4);
        check("blob_const_iters", 32'(iters), 2);
        check("blob_const_conv", 32'(conv), 1);
        compare_cap("blob", 1);
        check("cap_const_cx", 32'(c_cx[0]), 5);
        check("cap_const_cy", 32'(c_cy[0]), 2);
        check("cap_const_iters", 32'(c_iters), 1);
        check("cap_const_conv", 32'(c_conv), 0);

        // Two blobs, k=2
        two_blob_frame();
        set_seeds(0, 0, 15, 3, 0, 0);
        load_seeds();
        send_frame(2, 1'b0);
        wait_pulse("two");
        compare_main("two", 2);
        check("two_const_c0", 32'({cx[0], cy[0]}), 32'({4'd1, 2'd0}));
        check("two_const_c1", 32'({cx[1], cy[1]}), 32'({4'd13, 2'd2}));
        check("two_const_m", 32'({mass[1], mass[0]}), 32'({12'd4, 12'd4}));

        // Tie with an empty third cluster, k=3
        set_seeds(0, 0, 15, 3, 0, 0);
        load_seeds();
        send_frame(3, 1'b0);
        wait_pulse("tie");
        compare_main("tie", 3);
        check("tie_const_m2", 32'(mass[2]), 0);
        check("tie_const_c2", 32'({cx[2], cy[2]}), 0);

        // Empty frame with loads attempted mid-SCAN
        clear_frame();
        set_seeds(3, 1, 10, 2, 7, 0);
        load_seeds();
        send_frame(2, 1'b0);
        repeat (3) @(negedge clk_in);
        check("empty_busy", 32'(busy), 1);
        seed_x_in = '1; seed_y_in = '1;
        seed_valid_in = 1'b1; frame_done_in = 1'b1;
        pixel_valid_in = 1'b1; mask_in = 1'b1; x_in = 4'd5; y_in = 2'd1;
        @(negedge clk_in);
        seed_valid_in = 1'b0; frame_done_in = 1'b0; pixel_valid_in = 1'b0; mask_in = 1'b0;
        wait_pulse("empty");
        compare_main("empty", 2);
        check("empty_const_iters", 32'(iters), 1);
        check("empty_const_c0", 32'({cx[0], cy[0]}), 32'({4'd3, 2'd1}));

        // Asynchronous reset while dividing
        single_blob_frame();
        set_seeds(0, 0, 0, 0, 0, 0);
        load_seeds();
        send_frame(1, 1'b0);
        repeat (20) @(negedge clk_in);
        check("div_busy", 32'(busy), 1);
        #2 rst_in = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_cx", 32'(cx), 0);
        check("arst_cy", 32'(cy), 0);
        check("arst_mass", 32'(|mass), 0);
        check("arst_iters", 32'(iters), 0);
        check("arst_conv", 32'(conv), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        load_seeds();
        send_frame(1, 1'b0);
        wait_pulse("rerun");
        compare_main("rerun", 1);
        check("rerun_const_c0", 32'({cx[0], cy[0]}), 32'({4'd5, 2'd2}));

        // Randomized frames, seeds and k (k=0 exercises the clamp)
        for (int r = 0; r < 8; r++) begin
            k = int'($urandom_range(0, 3));
            dens = int'($urandom_range(1, 4));
            for (int j = 0; j < K; j++) begin
                seed_x[j] = int'($urandom_range(0, W - 1));
                seed_y[j] = int'($urandom_range(0, H - 1));
            end
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) frame[y][x] = (int'($urandom % 8) < dens);
            if (r % 2 == 0) load_seeds();
            send_frame(k, r % 2 == 1);
            wait_pulse($sformatf("rnd%0d", r));
            compare_main($sformatf("rnd%0d", r), k);
            compare_cap($sformatf("rnd%0d", r), k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
